// File: rtl/mar_mdr_mem_if.sv
// MAR/MDR memory-interface stage: holds the address and data registers loaded
// from the datapath bus and runs fixed-length SRAM read/write cycles on request.
module mar_mdr_mem_if #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MEM_WAIT = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mar_out,
  output logic [DATA_W-1:0] mdr_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ce,
  output logic              mem_oe,
  output logic              mem_we,
  output logic              busy,
  output logic              ready,
  output logic              req_err
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  localparam logic [3:0] LAST = 4'(MEM_WAIT - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;

  // Strobes, busy and ready are registered alongside the state transition so
  // they never carry a combinational path from the request inputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      mar     <= '0;
      mdr     <= '0;
      mem_ce  <= 1'b0;
      mem_oe  <= 1'b0;
      mem_we  <= 1'b0;
      busy    <= 1'b0;
      ready   <= 1'b0;
      req_err <= 1'b0;
    end else begin
      ready   <= 1'b0;
      req_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (LD_MAR) mar <= ADDR_W'(bus_in);
          if (LD_MDR) mdr <= bus_in;
          if (rd_req && wr_req) begin
            req_err <= 1'b1;
          end else if (rd_req) begin
            state  <= RD;
            mem_ce <= 1'b1;
            mem_oe <= 1'b1;
            busy   <= 1'b1;
          end else if (wr_req) begin
            state  <= WR;
            mem_ce <= 1'b1;
            mem_we <= 1'b1;
            busy   <= 1'b1;
          end
        end
        RD, WR: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST) begin
            if (state == RD) mdr <= mem_rdata;
            state  <= DONE;
            mem_ce <= 1'b0;
            mem_oe <= 1'b0;
            mem_we <= 1'b0;
            ready  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mar_out   = mar;
  assign mdr_out   = mdr;
  assign mem_addr  = mar;
  assign mem_wdata = mdr;

endmodule

// File: doc/mar_mdr_mem_if.md
Name: mar_mdr_mem_if

Overview:
- Memory-interface stage between the datapath bus and external SRAM.
- Holds the MAR and MDR registers and loads both from the bus output.
- Runs fixed-wait-state SRAM read/write cycles under control-unit requests.
- Drives mdr_out, which feeds the bus MDR source input; signals completion to the control FSM with a one-cycle ready pulse.

Parameters:
- ADDR_W, 16, MAR and SRAM address width.
- DATA_W, 16, MDR and SRAM data width.
- MEM_WAIT, 2, SRAM access length in cycles; legal range 1..15.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- bus_in  in  DATA_W  datapath bus value.
- LD_MAR  in  1  load MAR from bus_in.
- LD_MDR  in  1  load MDR from bus_in.
- rd_req  in  1  single-cycle pulse: start SRAM read at MAR.
- wr_req  in  1  single-cycle pulse: start SRAM write of MDR to MAR.
- mem_rdata  in  DATA_W  SRAM read data.
- mar_out  out  ADDR_W  MAR register value.
- mdr_out  out  DATA_W  MDR register value; drives bus MDR input.
- mem_addr  out  ADDR_W  SRAM address.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_ce  out  1  SRAM chip enable, active-high.
- mem_oe  out  1  SRAM output enable, active-high.
- mem_we  out  1  SRAM write enable, active-high.
- busy  out  1  high whenever state is not IDLE.
- ready  out  1  one-cycle completion pulse.
- req_err  out  1  one-cycle pulse on illegal simultaneous request.

Behaviour:
- Reset (synchronous; wins over every other input):
  - Next edge: state=IDLE, MAR=0, MDR=0, wait counter=0.
  - All outputs are 0 after reset.
- Reset mid-access aborts the access with no MDR capture; mem_ce etc. are 0 from the cycle after the reset edge.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - mem_ce, mem_oe, mem_we, busy and ready are all 0.
  - LD_MAR: MAR<=bus_in. LD_MDR: MDR<=bus_in. Both may load on the same edge.
  - rd_req only: go to RD, counter<=0.
  - wr_req only: go to WR, counter<=0.
  - rd_req and wr_req together: stay in IDLE; req_err=1 in the next cycle; no access.
- Request with LD_MAR/LD_MDR on the same edge: register loads on that edge, so the access uses the new MAR/MDR.
- RD:
  - mem_ce=1, mem_oe=1, mem_we=0, mem_addr=MAR.
  - counter increments each edge.
  - On the edge where counter==MEM_WAIT-1: MDR<=mem_rdata, go to DONE.
- WR:
  - mem_ce=1, mem_we=1, mem_oe=0, mem_addr=MAR, mem_wdata=MDR.
  - Leaves for DONE on the same counter condition; MDR is unchanged.
- DONE: ready=1, busy=1, SRAM strobes 0; unconditionally returns to IDLE next edge.
- Latency: the request edge is followed by MEM_WAIT cycles of access, then 1 DONE cycle. A new request is first accepted on the edge ending DONE+1 (the first IDLE cycle).
- While busy:
  - rd_req, wr_req, LD_MAR and LD_MDR are ignored; MAR and MDR stay stable.
  - Exception: RD capture into MDR.
- Outside RD/WR, mem_addr=MAR and mem_wdata=MDR, but the SRAM strobes are 0.
- mar_out and mdr_out are direct register outputs with no combinational path from inputs.
- Counter width is 4 bits; no wrap is possible within the legal MEM_WAIT range.

Test Plan:
- Reset then idle (MEM_WAIT=2) -> mar_out=0, mdr_out=0, busy=0, ready=0, all mem strobes 0.
- bus_in=0x3000 with LD_MAR, then rd_req; mem_rdata=0xBEEF:
  - mem_ce/mem_oe high for exactly 2 cycles with mem_addr=0x3000.
  - ready pulses in cycle 3 after the request; mdr_out=0xBEEF in that same cycle.
- LD_MAR (0x0040) and LD_MDR (0x1234) together with wr_req on one edge -> mem_we high 2 cycles, mem_addr=0x0040, mem_wdata=0x1234; MDR stays 0x1234; ready pulses once.
- rd_req and wr_req asserted in the same cycle -> req_err=1 for one cycle, busy stays 0, no strobes.
- LD_MAR=0xFFFF and rd_req pulsed during an active read -> both ignored: MAR unchanged, single ready pulse, busy low after DONE.
- Reset asserted in the 2nd RD cycle with mem_rdata=0xAAAA -> next cycle state IDLE, mdr_out=0, strobes 0, no ready pulse.
